fpu_inflight_tracker: RTL and testbench
=======================================

// Module: fpu_inflight_tracker
// PURPOSE
//  In-order tracker for instructions offloaded to rvfpm over CORE-V-XIF. Allocates an entry per accepted issue,
//  records commit/kill from the core and execute-done data from the FPU pipeline, then releases results in
//  program order on the XIF result channel. Also exports a destination-register busy map for issue hazard stalls.
// PARAMETERS
//  DEPTH       4   in-flight entries; power of 2, >=2
//  X_ID_WIDTH  4   XIF instruction id width
//  FLEN        32  result data width
//  NUM_REGS    32  FP register count; rd is $clog2(NUM_REGS) bits
// PORTS
//  ck              in   1           clock, rising edge
//  rst             in   1           reset, synchronous, active-high
//  issue_accept_i  in   1           issue_valid & issue_ready & accept this cycle
//  issue_id_i      in   X_ID_WIDTH  id of accepted instruction
//  issue_rd_i      in   log2(NUM_REGS) FP destination register
//  issue_we_i      in   1           instruction writes an FP register
//  commit_valid_i  in   1           XIF commit strobe
//  commit_id_i     in   X_ID_WIDTH  id being committed/killed
//  commit_kill_i   in   1           1 = kill, 0 = commit
//  done_valid_i    in   1           FPU pipeline finished an instruction
//  done_id_i       in   X_ID_WIDTH  id of finished instruction
//  done_data_i     in   FLEN        result value
//  result_valid_o  out  1           XIF result valid
//  result_ready_i  in   1           XIF result ready
//  result_id_o     out  X_ID_WIDTH  result id
//  result_data_o   out  FLEN        result data
//  result_rd_o     out  log2(NUM_REGS) result rd
//  result_we_o     out  1           result writes register
//  kill_valid_o    out  1           1-cycle pulse: cancel kill_id_o in FPU pipeline
//  kill_id_o       out  X_ID_WIDTH  id to cancel
//  rd_busy_o       out  NUM_REGS    bit r set if a live entry with we=1 targets r
//  full_o          out  1           count == DEPTH
//  empty_o         out  1           count == 0
//  overflow_o      out  1           sticky: accept seen while full
// BEHAVIOUR
//  - Reset: all entries FREE, head=tail=count=0; all outputs 0 except empty_o=1. Reset mid-operation discards all
//    entries; no result or kill is emitted for them.
//  - Storage: circular buffer, head/tail wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  - Entry FSM: FREE -> ALLOC (on issue) -> ALLOC sets flags committed, done, killed independently -> FREE on release.
//  - Issue: issue_accept_i & !full_o writes entry at tail {id,rd,we}, flags cleared, tail++. Accept while full:
//    dropped, overflow_o set until rst.
//  - Commit/kill: matched by id against live, non-killed entries; unmatched ids ignored. Commit sets committed.
//    Kill sets killed and pulses kill_valid_o/kill_id_o the next cycle.
//  - Done: matching live entry latches done_data_i, sets done; done for killed/unknown id ignored.
//  - Release (at most one per cycle, head only):
//    * head killed: freed next cycle, no result.
//    * head committed & done & !killed: result_* driven from registers, valid the cycle after the last flag is set;
//      held stable until result_valid_o & result_ready_i, then head++ and next head may present next cycle.
//  - Simultaneous: alloc + release same cycle -> count unchanged; commit and done to same entry same cycle both
//    take effect; done/commit and alloc of a different id same cycle both take effect.
//  - rd_busy_o: combinational OR over live, non-killed entries with we=1; cleared the cycle after release/kill.
//  - full_o/empty_o derived from registered count.
// TESTING
//  1. Issue id 3 rd 5 we=1; commit id 3; done id 3 data 0x3F800000 -> result_valid_o next cycle, id 3, rd 5,
//     data 0x3F800000; rd_busy_o[5]=1 until handshake, then 0.
//  2. Issue ids 1,2; done 2 then done 1; commit both -> results released id 1 then id 2 (program order).
//  3. Issue id 4; kill id 4 -> kill_valid_o pulse with id 4, no result; later done id 4 ignored; empty_o=1.
//  4. Fill DEPTH=4 entries -> full_o=1; fifth accept -> dropped, overflow_o=1; release head with accept same cycle
//     -> count stays 4, new entry stored.
//  5. result_ready_i low 3 cycles on valid result -> result_* stable, no head advance; ready high -> advance.
//  6. rst asserted with 3 live entries -> next cycle empty_o=1, result_valid_o=0, rd_busy_o=0, no kill pulses.

Source files
------------

// File: rtl/fpu_inflight_tracker.sv
// In-order tracker for FPU instructions offloaded over XIF: allocates on issue, collects commit/kill and
// execute results, and releases results strictly in program order from the head of a circular buffer.
module fpu_inflight_tracker #(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4,
    parameter int FLEN       = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic                          issue_accept_i,
    input  logic [X_ID_WIDTH-1:0]         issue_id_i,
    input  logic [$clog2(NUM_REGS)-1:0]   issue_rd_i,
    input  logic                          issue_we_i,
    input  logic                          commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]         commit_id_i,
    input  logic                          commit_kill_i,
    input  logic                          done_valid_i,
    input  logic [X_ID_WIDTH-1:0]         done_id_i,
    input  logic [FLEN-1:0]               done_data_i,
    output logic                          result_valid_o,
    input  logic                          result_ready_i,
    output logic [X_ID_WIDTH-1:0]         result_id_o,
    output logic [FLEN-1:0]               result_data_o,
    output logic [$clog2(NUM_REGS)-1:0]   result_rd_o,
    output logic                          result_we_o,
    output logic                          kill_valid_o,
    output logic [X_ID_WIDTH-1:0]         kill_id_o,
    output logic [NUM_REGS-1:0]           rd_busy_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic                          overflow_o
);

    // state   | meaning
    // E_FREE  | slot unused, ignored by commit/done matching and the busy map
    // E_ALLOC | slot holds an in-flight instruction; committed/done/killed flags track its progress

    localparam int RD_W  = $clog2(NUM_REGS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {E_FREE, E_ALLOC} ent_state_t;

    ent_state_t            st_q   [DEPTH];
    ent_state_t            st_d   [DEPTH];
    logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
    logic [X_ID_WIDTH-1:0] id_d   [DEPTH];
    logic [RD_W-1:0]       rd_q   [DEPTH];
    logic [RD_W-1:0]       rd_d   [DEPTH];
    logic [FLEN-1:0]       data_q [DEPTH];
    logic [FLEN-1:0]       data_d [DEPTH];
    logic                  we_q   [DEPTH];
    logic                  we_d   [DEPTH];
    logic                  cmt_q  [DEPTH];
    logic                  cmt_d  [DEPTH];
    logic                  dn_q   [DEPTH];
    logic                  dn_d   [DEPTH];
    logic                  kil_q  [DEPTH];
    logic                  kil_d  [DEPTH];

    logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  kv_q, kv_d;
    logic [X_ID_WIDTH-1:0] kid_q, kid_d;

    logic head_live, res_valid, release_en, alloc_en;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign head_live = (st_q[head_q] == E_ALLOC);
    assign res_valid = head_live && cmt_q[head_q] && dn_q[head_q] && !kil_q[head_q];
    assign release_en = (head_live && kil_q[head_q]) || (res_valid && result_ready_i);
    // A head release frees a slot in the same cycle, so an accept while full still fits then.
    assign alloc_en  = issue_accept_i && (!full_o || release_en);

    assign result_valid_o = res_valid;
    assign result_id_o    = id_q[head_q];
    assign result_data_o  = data_q[head_q];
    assign result_rd_o    = rd_q[head_q];
    assign result_we_o    = we_q[head_q];
    assign kill_valid_o   = kv_q;
    assign kill_id_o      = kid_q;
    assign overflow_o     = ovf_q;

    always_comb begin
        st_d    = st_q;
        id_d    = id_q;
        rd_d    = rd_q;
        data_d  = data_q;
        we_d    = we_q;
        cmt_d   = cmt_q;
        dn_d    = dn_q;
        kil_d   = kil_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q || (issue_accept_i && !alloc_en);
        kv_d    = 1'b0;
        kid_d   = kid_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] == E_ALLOC && !kil_q[i]) begin
                if (commit_valid_i && commit_id_i == id_q[i]) begin
                    if (commit_kill_i) begin
                        kil_d[i] = 1'b1;
                        kv_d     = 1'b1;
                        kid_d    = commit_id_i;
                    end else begin
                        cmt_d[i] = 1'b1;
                    end
                end
                if (done_valid_i && done_id_i == id_q[i]) begin
                    dn_d[i]   = 1'b1;
                    data_d[i] = done_data_i;
                end
            end
        end

        if (release_en) begin
            st_d[head_q] = E_FREE;
            head_d       = head_q + 1'b1;
        end

        // Allocation comes last so it wins when the tail slot is the one just released.
        if (alloc_en) begin
            st_d[tail_q]  = E_ALLOC;
            id_d[tail_q]  = issue_id_i;
            rd_d[tail_q]  = issue_rd_i;
            we_d[tail_q]  = issue_we_i;
            cmt_d[tail_q] = 1'b0;
            dn_d[tail_q]  = 1'b0;
            kil_d[tail_q] = 1'b0;
            tail_d        = tail_q + 1'b1;
        end

        if (alloc_en && !release_en) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_en && release_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_q[i] == E_ALLOC && !kil_q[i] && we_q[i]) begin
                rd_busy_o[rd_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_q[i]   <= E_FREE;
                id_q[i]   <= '0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
                we_q[i]   <= 1'b0;
                cmt_q[i]  <= 1'b0;
                dn_q[i]   <= 1'b0;
                kil_q[i]  <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            kv_q    <= 1'b0;
            kid_q   <= '0;
        end else begin
            st_q    <= st_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            we_q    <= we_d;
            cmt_q   <= cmt_d;
            dn_q    <= dn_d;
            kil_q   <= kil_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            kv_q    <= kv_d;
            kid_q   <= kid_d;
        end
    end

endmodule

// File: tb/tb_fpu_inflight_tracker.sv
module tb_fpu_inflight_tracker;

   logic        ck = 1'b0;
   logic        rst;
   logic        issue_accept;
   logic [3:0]  issue_id;
   logic [4:0]  issue_rd;
   logic        issue_we;
   logic        commit_valid;
   logic [3:0]  commit_id;
   logic        commit_kill;
   logic        done_valid;
   logic [3:0]  done_id;
   logic [31:0] done_data;
   logic        result_valid;
   logic        result_ready;
   logic [3:0]  result_id;
   logic [31:0] result_data;
   logic [4:0]  result_rd;
   logic        result_we;
   logic        kill_valid;
   logic [3:0]  kill_id;
   logic [31:0] rd_busy;
   logic        full;
   logic        empty;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   always #5 ck = ~ck;

   fpu_inflight_tracker #(.DEPTH(4), .X_ID_WIDTH(4), .FLEN(32), .NUM_REGS(32)) dut (
      .ck             (ck),
      .rst            (rst),
      .issue_accept_i (issue_accept),
      .issue_id_i     (issue_id),
      .issue_rd_i     (issue_rd),
      .issue_we_i     (issue_we),
      .commit_valid_i (commit_valid),
      .commit_id_i    (commit_id),
      .commit_kill_i  (commit_kill),
      .done_valid_i   (done_valid),
      .done_id_i      (done_id),
      .done_data_i    (done_data),
      .result_valid_o (result_valid),
      .result_ready_i (result_ready),
      .result_id_o    (result_id),
      .result_data_o  (result_data),
      .result_rd_o    (result_rd),
      .result_we_o    (result_we),
      .kill_valid_o   (kill_valid),
      .kill_id_o      (kill_id),
      .rd_busy_o      (rd_busy),
      .full_o         (full),
      .empty_o        (empty),
      .overflow_o     (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic do_issue(input logic [3:0] id, input logic [4:0] rd, input logic we);
      issue_accept = 1'b1; issue_id = id; issue_rd = rd; issue_we = we;
      tick();
      issue_accept = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] id, input logic kill);
      commit_valid = 1'b1; commit_id = id; commit_kill = kill;
      tick();
      commit_valid = 1'b0; commit_kill = 1'b0;
   endtask

   task automatic do_done(input logic [3:0] id, input logic [31:0] data);
      done_valid = 1'b1; done_id = id; done_data = data;
      tick();
      done_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      issue_accept = 1'b0; issue_id = '0; issue_rd = '0; issue_we = 1'b0;
      commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
      done_valid = 1'b0; done_id = '0; done_data = '0;
      result_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      check("reset_empty", empty, 1'b1);
      check("reset_full", full, 1'b0);
      check("reset_valid", result_valid, 1'b0);
      check("reset_busy", rd_busy, 32'h0);
      check("reset_ovf", overflow, 1'b0);
      check("reset_kill", kill_valid, 1'b0);

      do_issue(4'd3, 5'd5, 1'b1);
      check("t1_busy5", rd_busy[5], 1'b1);
      check("t1_not_empty", empty, 1'b0);
      do_commit(4'd3, 1'b0);
      check("t1_valid_pre_done", result_valid, 1'b0);
      do_done(4'd3, 32'h3F80_0000);
      check("t1_valid", result_valid, 1'b1);
      check("t1_id", result_id, 4'd3);
      check("t1_rd", result_rd, 5'd5);
      check("t1_data", result_data, 32'h3F80_0000);
      check("t1_we", result_we, 1'b1);
      check("t1_busy_held", rd_busy[5], 1'b1);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("t1_valid_after", result_valid, 1'b0);
      check("t1_busy_clear", rd_busy[5], 1'b0);
      check("t1_empty", empty, 1'b1);

      do_issue(4'd1, 5'd1, 1'b1);
      do_issue(4'd2, 5'd2, 1'b1);
      do_done(4'd2, 32'hAAAA_0002);
      do_done(4'd1, 32'hBBBB_0001);
      check("t2_valid_uncommitted", result_valid, 1'b0);
      do_commit(4'd1, 1'b0);
      do_commit(4'd2, 1'b0);
      check("t2_first_id", result_id, 4'd1);
      check("t2_first_data", result_data, 32'hBBBB_0001);
      result_ready = 1'b1;
      tick();
      check("t2_second_valid", result_valid, 1'b1);
      check("t2_second_id", result_id, 4'd2);
      check("t2_second_data", result_data, 32'hAAAA_0002);
      tick();
      result_ready = 1'b0;
      check("t2_drained", empty, 1'b1);
      check("t2_valid_off", result_valid, 1'b0);

      do_issue(4'd4, 5'd7, 1'b1);
      check("t3_busy7", rd_busy[7], 1'b1);
      do_commit(4'd4, 1'b1);
      check("t3_kill_pulse", kill_valid, 1'b1);
      check("t3_kill_id", kill_id, 4'd4);
      check("t3_busy7_clear", rd_busy[7], 1'b0);
      check("t3_no_result", result_valid, 1'b0);
      tick();
      check("t3_kill_one_cycle", kill_valid, 1'b0);
      check("t3_empty", empty, 1'b1);
      do_done(4'd4, 32'h1234_5678);
      check("t3_done_ignored_valid", result_valid, 1'b0);
      check("t3_done_ignored_empty", empty, 1'b1);

      do_issue(4'd5, 5'd3, 1'b0);
      check("t3b_no_busy", rd_busy, 32'h0);
      commit_valid = 1'b1; commit_id = 4'd5; commit_kill = 1'b0;
      done_valid = 1'b1; done_id = 4'd5; done_data = 32'h0000_5555;
      tick();
      commit_valid = 1'b0; done_valid = 1'b0;
      check("t3b_valid", result_valid, 1'b1);
      check("t3b_we", result_we, 1'b0);
      check("t3b_data", result_data, 32'h0000_5555);
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("t3b_empty", empty, 1'b1);

      do_issue(4'd8, 5'd8, 1'b1);
      do_issue(4'd9, 5'd9, 1'b1);
      do_issue(4'd10, 5'd10, 1'b1);
      check("t4_not_full3", full, 1'b0);
      do_issue(4'd11, 5'd11, 1'b1);
      check("t4_full", full, 1'b1);
      check("t4_ovf_clear", overflow, 1'b0);
      do_issue(4'd12, 5'd12, 1'b1);
      check("t4_ovf", overflow, 1'b1);
      check("t4_dropped", rd_busy[12], 1'b0);
      check("t4_still_full", full, 1'b1);
      do_commit(4'd8, 1'b0);
      do_done(4'd8, 32'h0000_0008);
      check("t4_head8", result_id, 4'd8);
      result_ready = 1'b1;
      do_issue(4'd13, 5'd13, 1'b1);
      result_ready = 1'b0;
      check("t4_full_after_swap", full, 1'b1);
      check("t4_new_busy13", rd_busy[13], 1'b1);
      check("t4_busy8_clear", rd_busy[8], 1'b0);
      check("t4_ovf_sticky", overflow, 1'b1);
      check("t4_next_head_wait", result_valid, 1'b0);

      do_commit(4'd9, 1'b0);
      do_done(4'd9, 32'hC0DE_0009);
      for (int i = 0; i < 3; i++) begin
         check("t5_hold_valid", result_valid, 1'b1);
         check("t5_hold_id", result_id, 4'd9);
         check("t5_hold_data", result_data, 32'hC0DE_0009);
         check("t5_hold_full", full, 1'b1);
         tick();
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("t5_advanced_valid", result_valid, 1'b0);
      check("t5_advanced_full", full, 1'b0);
      check("t5_head10", result_id, 4'd10);

      check("t6_live", empty, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_empty", empty, 1'b1);
      check("t6_valid", result_valid, 1'b0);
      check("t6_busy", rd_busy, 32'h0);
      check("t6_kill", kill_valid, 1'b0);
      check("t6_ovf", overflow, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_quiet_kill", kill_valid, 1'b0);
         check("t6_quiet_valid", result_valid, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
